// File: rtl/board_output_reader.sv
// Drains one per-board output SpyBuffer FIFO onto a valid/ready stream, checking
// header/footer framing on capture and keeping event/word/error counters.
module board_output_reader #(
  parameter int          DATA_WIDTH = 65,
  parameter int          LEN_WIDTH  = 12,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [7:0]  HDR_MARK   = 8'hAB,
  parameter logic [7:0]  FTR_MARK   = 8'hCD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [LEN_WIDTH-1:0]  out_len,
  output logic [CNT_WIDTH-1:0]  event_count,
  output logic [CNT_WIDTH-1:0]  err_orphan_count,
  output logic [CNT_WIDTH-1:0]  err_nofooter_cnt,
  output logic                  dbg_state
);

  // Stream handshake: a beat transfers on a rising clock edge where out_valid
  // and out_ready are both high; while out_valid && !out_ready the head entry
  // (out_data/out_last/out_len) is held unchanged, and out_valid never drops
  // without a transfer.

  typedef enum logic {
    IDLE  = 1'b0,
    INEVT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [LEN_WIDTH-1:0]  len;
  } entry_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = {LEN_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   rd_pending_q;
  logic [1:0]             count_q, count_d;
  entry_t                 slot0_q, slot1_q, slot0_d, slot1_d;
  entry_t                 new_entry;
  logic [LEN_WIDTH-1:0]   len_q, len_d, len_inc;
  logic [CNT_WIDTH-1:0]   event_q, orphan_q, nofooter_q;
  logic                   is_hdr, is_ftr;
  logic                   push, pop;
  logic                   evt_inc, orph_inc, nof_inc;
  logic [2:0]             occ_next;

  assign pop     = (count_q != 2'd0) && out_ready;
  assign is_hdr  = fifo_read_data[DATA_WIDTH-1] && (fifo_read_data[DATA_WIDTH-2 -: 8] == HDR_MARK);
  assign is_ftr  = fifo_read_data[DATA_WIDTH-1] && (fifo_read_data[DATA_WIDTH-2 -: 8] == FTR_MARK);
  assign len_inc = (len_q == LEN_MAX) ? len_q : len_q + LEN_ONE;

  // A new read is allowed only if, after this cycle's pop, the held words plus
  // the read already in flight plus this one still fit in two slots.
  assign occ_next         = {1'b0, count_q} - {2'b00, pop} + {2'b00, rd_pending_q} + 3'd1;
  assign fifo_read_enable = reset && !fifo_empty && (occ_next <= 3'd2);

  // Framing FSM: classifies the captured word and decides whether it is buffered.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    push           = 1'b0;
    evt_inc        = 1'b0;
    orph_inc       = 1'b0;
    nof_inc        = 1'b0;
    new_entry.data = fifo_read_data;
    new_entry.last = 1'b0;
    new_entry.len  = '0;
    if (rd_pending_q) begin
      case (state_q)
        IDLE: begin
          if (is_hdr) begin
            push    = 1'b1;
            len_d   = LEN_ONE;
            state_d = INEVT;
          end else begin
            orph_inc = 1'b1;
          end
        end
        INEVT: begin
          if (is_hdr) begin
            nof_inc = 1'b1;
            push    = 1'b1;
            len_d   = LEN_ONE;
          end else if (is_ftr) begin
            push           = 1'b1;
            new_entry.last = 1'b1;
            new_entry.len  = len_inc;
            evt_inc        = 1'b1;
            state_d        = IDLE;
          end else begin
            push  = 1'b1;
            len_d = len_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Two-slot buffer, slot0 is always the head.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = new_entry;
        else                 slot1_d = new_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = new_entry;
        end else begin
          slot0_d = slot1_q;
          slot1_d = new_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      rd_pending_q <= 1'b0;
      count_q      <= 2'd0;
      slot0_q      <= '0;
      slot1_q      <= '0;
      len_q        <= '0;
      event_q      <= '0;
      orphan_q     <= '0;
      nofooter_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= fifo_read_enable;
      count_q      <= count_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      len_q        <= len_d;
      if (evt_inc)  event_q    <= event_q + CNT_ONE;
      if (orph_inc) orphan_q   <= orphan_q + CNT_ONE;
      if (nof_inc)  nofooter_q <= nofooter_q + CNT_ONE;
    end
  end

  assign out_valid        = (count_q != 2'd0);
  assign out_data         = slot0_q.data;
  assign out_last         = slot0_q.last;
  assign out_len          = slot0_q.len;
  assign event_count      = event_q;
  assign err_orphan_count = orphan_q;
  assign err_nofooter_cnt = nofooter_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_board_output_reader.sv
// Bench for board_output_reader: queue-based FIFO source, event-level reference
// model of the framing rules, per-scenario tasks comparing stream and counters.
module tb_board_output_reader;

  localparam int DW      = 65;
  localparam int LW      = 4;
  localparam int CW      = 32;
  localparam int EW      = DW + 1 + LW;
  localparam int LEN_MAX = (1 << LW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_enable;
  logic [DW-1:0] fifo_read_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [LW-1:0] out_len;
  logic [CW-1:0] event_count, err_orphan_count, err_nofooter_cnt;
  logic          dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] src_q[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  int            m_in_evt = 0;
  int            m_len    = 0;
  logic [CW-1:0] m_evt = '0, m_orph = '0, m_nof = '0;
  int            rd_cnt = 0, bt_cnt = 0;

  always #5 clock = ~clock;

  board_output_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_read_enable(fifo_read_enable), .fifo_read_data(fifo_read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_len(out_len), .event_count(event_count),
    .err_orphan_count(err_orphan_count), .err_nofooter_cnt(err_nofooter_cnt),
    .dbg_state(dbg_state)
  );

  // Registered-output FIFO: data appears the cycle after a read request.
  always @(posedge clock) begin : fifo_model
    logic [DW-1:0] w;
    if (fifo_read_enable && src_q.size() > 0) begin
      w = src_q.pop_front();
      fifo_read_data <= w;
    end
    if (fifo_read_enable) rd_cnt++;
    if (out_valid && out_ready) bt_cnt++;
    #3 fifo_empty = (src_q.size() == 0);
  end

  always @(negedge clock)
    if (reset && out_valid && out_ready) got_q.push_back({out_data, out_last, out_len});

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [DW-1:0] mk_word(input logic flag, input logic [7:0] mark);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {flag, mark, r[55:0]};
  endfunction

  function automatic logic [DW-1:0] mk_data();
    return mk_word(1'($urandom_range(0, 1)), 8'($urandom_range(0, 170)));
  endfunction

  // Event-level model: what the stream and counters should show for a word.
  task automatic model_word(input logic [DW-1:0] w);
    logic hdr, ftr;
    int   l;
    hdr = w[DW-1] && (w[DW-2 -: 8] == 8'hAB);
    ftr = w[DW-1] && (w[DW-2 -: 8] == 8'hCD);
    if (m_in_evt == 0) begin
      if (hdr) begin
        exp_q.push_back({w, 1'b0, LW'(0)});
        m_len = 1;
        m_in_evt = 1;
      end else begin
        m_orph++;
      end
    end else if (hdr) begin
      m_nof++;
      exp_q.push_back({w, 1'b0, LW'(0)});
      m_len = 1;
    end else if (ftr) begin
      l = (m_len + 1 > LEN_MAX) ? LEN_MAX : m_len + 1;
      exp_q.push_back({w, 1'b1, LW'(l)});
      m_evt++;
      m_in_evt = 0;
    end else begin
      m_len++;
      exp_q.push_back({w, 1'b0, LW'(0)});
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    src_q.push_back(w);
    model_word(w);
  endtask

  task automatic model_reset();
    m_in_evt = 0; m_len = 0; m_evt = '0; m_orph = '0; m_nof = '0;
    exp_q.delete(); got_q.delete();
  endtask

  // mode 0: ready held high, 1: toggling, 2: random
  task automatic drain(input int mode, input int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || got_q.size() < exp_q.size()) && n < budget) begin
      @(posedge clock); #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      n++;
    end
    repeat (4) begin @(posedge clock); #1; out_ready = 1'b1; end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain_timeout got=%0d beats required=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] w;
    reset = 1'b0;
    out_ready = 1'b0;
    w = mk_data();
    send(w);
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if ({out_valid, out_last, out_len, out_data, fifo_read_enable, event_count,
         err_orphan_count, err_nofooter_cnt, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_outputs valid=%b re=%b evt=%0d state=%b required all zero",
               out_valid, fifo_read_enable, event_count, dbg_state);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    drain(0, 50);
    total++;
    if ({err_orphan_count, event_count, err_nofooter_cnt} !== {32'd1, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_first_orphan orphan=%0d evt=%0d nof=%0d required 1 0 0",
               err_orphan_count, event_count, err_nofooter_cnt);
    end
  endtask

  task automatic test_basic_event();
    logic [CW-1:0] e0;
    logic [EW-1:0] lastb;
    int t_re, t_v, t_last, run;
    e0 = event_count;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    send(mk_word(1'b1, 8'hAB)); send(mk_data()); send(mk_data()); send(mk_word(1'b1, 8'hCD));
    t_re = -1; t_v = -1; t_last = -1; run = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (fifo_read_enable && t_re < 0) t_re = c;
      if (out_valid) begin
        if (t_v < 0) t_v = c;
        t_last = c;
        run++;
      end
    end
    @(posedge clock); #1;
    drain(0, 50);
    total++;
    if (t_re < 0 || t_v - t_re != 2) begin
      bad++; $display("FAIL t1_latency got=%0d required=2", t_v - t_re);
    end
    total++;
    if (run != 4 || t_last - t_v != 3) begin
      bad++; $display("FAIL t1_back_to_back valid_cycles=%0d span=%0d required 4 4", run, t_last - t_v + 1);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL t1_beats got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL t1_beat%0d got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    lastb = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
    total++;
    if (lastb[LW:0] !== {1'b1, LW'(4)}) begin
      bad++; $display("FAIL t1_last_len got=%h required last=1 len=4", lastb[LW:0]);
    end
    total++;
    if (event_count - e0 !== 32'd1 || event_count !== m_evt) begin
      bad++; $display("FAIL t1_event_count got=%0d required=%0d", event_count, m_evt);
    end
  endtask

  task automatic test_stall_long();
    logic [EW:0] held;
    logic        held_v;
    int          maxocc, n;
    exp_q.delete(); got_q.delete();
    rd_cnt = 0; bt_cnt = 0;
    held = '0; held_v = 1'b0; maxocc = 0; n = 0;
    send(mk_word(1'b1, 8'hAB));
    for (int i = 0; i < 98; i++) send(mk_data());
    send(mk_word(1'b1, 8'hCD));
    while ((src_q.size() != 0 || got_q.size() < exp_q.size()) && n < 600) begin
      @(negedge clock);
      if (held_v) begin
        total++;
        if ({out_valid, out_data, out_last, out_len} !== held) begin
          bad++; $display("FAIL t2_stable got=%h required=%h", {out_valid, out_data, out_last, out_len}, held);
        end
      end
      held_v = out_valid && !out_ready;
      held = {out_valid, out_data, out_last, out_len};
      if (rd_cnt - bt_cnt > maxocc) maxocc = rd_cnt - bt_cnt;
      @(posedge clock); #1;
      out_ready = ~out_ready;
      n++;
    end
    repeat (4) begin @(posedge clock); #1; out_ready = 1'b1; end
    total++;
    if (n >= 600) begin bad++; $display("FAIL t2_timeout got=%0d required=%0d", got_q.size(), exp_q.size()); end
    total++;
    if (got_q.size() != 100) begin bad++; $display("FAIL t2_beats got=%0d required=100", got_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL t2_beat%0d got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++;
    if (maxocc > 3) begin bad++; $display("FAIL t2_occupancy got=%0d required<=3", maxocc); end
  endtask

  task automatic test_orphans();
    logic [CW-1:0] o0, e0;
    logic [EW-1:0] lastb;
    o0 = err_orphan_count; e0 = event_count;
    exp_q.delete(); got_q.delete();
    send(mk_data()); send(mk_word(1'b1, 8'hCD));
    send(mk_word(1'b1, 8'hAB)); send(mk_word(1'b1, 8'hCD));
    drain(0, 100);
    total++;
    if (err_orphan_count - o0 !== 32'd2 || event_count - e0 !== 32'd1) begin
      bad++; $display("FAIL t3_counts orphan+%0d evt+%0d required 2 1", err_orphan_count - o0, event_count - e0);
    end
    total++;
    if (got_q.size() != 2) begin bad++; $display("FAIL t3_beats got=%0d required=2", got_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL t3_beat%0d got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    lastb = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
    total++;
    if (lastb[LW:0] !== {1'b1, LW'(2)}) begin bad++; $display("FAIL t3_last_len got=%h required last=1 len=2", lastb[LW:0]); end
  endtask

  task automatic test_nofooter();
    logic [CW-1:0] n0, e0;
    logic [EW-1:0] lastb;
    int nlast;
    n0 = err_nofooter_cnt; e0 = event_count;
    exp_q.delete(); got_q.delete();
    send(mk_word(1'b1, 8'hAB)); send(mk_data());
    send(mk_word(1'b1, 8'hAB)); send(mk_data()); send(mk_word(1'b1, 8'hCD));
    drain(2, 200);
    nlast = 0;
    foreach (got_q[i]) if (got_q[i][LW]) nlast++;
    total++;
    if (got_q.size() != 5 || nlast != 1) begin
      bad++; $display("FAIL t4_beats got=%0d lasts=%0d required 5 1", got_q.size(), nlast);
    end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL t4_beat%0d got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    lastb = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
    total++;
    if (lastb[LW:0] !== {1'b1, LW'(3)}) begin bad++; $display("FAIL t4_last_len got=%h required last=1 len=3", lastb[LW:0]); end
    total++;
    if (err_nofooter_cnt - n0 !== 32'd1 || event_count - e0 !== 32'd1) begin
      bad++; $display("FAIL t4_counts nof+%0d evt+%0d required 1 1", err_nofooter_cnt - n0, event_count - e0);
    end
  endtask

  task automatic test_saturate();
    logic [CW-1:0] e0;
    logic [EW-1:0] lastb;
    e0 = event_count;
    exp_q.delete(); got_q.delete();
    send(mk_word(1'b1, 8'hAB));
    for (int i = 0; i < 18; i++) send(mk_data());
    send(mk_word(1'b1, 8'hCD));
    drain(2, 300);
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL t5_beat%0d got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    lastb = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
    total++;
    if (lastb[LW:0] !== {1'b1, LW'(15)}) begin bad++; $display("FAIL t5_sat_len got=%h required last=1 len=15", lastb[LW:0]); end
    total++;
    if (event_count - e0 !== 32'd1) begin bad++; $display("FAIL t5_event_count got=+%0d required=+1", event_count - e0); end
  endtask

  task automatic test_random();
    exp_q.delete(); got_q.delete();
    for (int e = 0; e < 40; e++) begin
      if ($urandom_range(0, 4) == 0) send(mk_data());
      send(mk_word(1'b1, 8'hAB));
      for (int i = $urandom_range(0, 20); i > 0; i--)
        send(($urandom_range(0, 7) == 0) ? mk_word(1'b0, 8'hAB) : mk_data());
      if ($urandom_range(0, 7) != 0) send(mk_word(1'b1, 8'hCD));
    end
    drain(2, 4000);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_beats got=%0d required=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rnd_beat%0d got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++;
    if ({event_count, err_orphan_count, err_nofooter_cnt} !== {m_evt, m_orph, m_nof}) begin
      bad++; $display("FAIL rnd_counters got=%0d/%0d/%0d required=%0d/%0d/%0d", event_count,
                      err_orphan_count, err_nofooter_cnt, m_evt, m_orph, m_nof);
    end
  endtask

  task automatic test_reset_mid_event();
    int seen, n;
    out_ready = 1'b0;
    src_q.push_back(mk_word(1'b1, 8'hAB));
    for (int i = 0; i < 5; i++) src_q.push_back(mk_data());
    seen = 0; n = 0;
    while (seen < 2 && n < 20) begin
      @(negedge clock);
      if (fifo_read_enable) seen++;
      n++;
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (fifo_read_enable !== 1'b0 || seen < 2) begin
      bad++; $display("FAIL t6_re_in_reset re=%b reads_seen=%0d required re=0 reads=2", fifo_read_enable, seen);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({out_valid, out_last, out_len, out_data, event_count, err_orphan_count,
         err_nofooter_cnt, dbg_state} !== '0) begin
      bad++; $display("FAIL t6_after_reset valid=%b evt=%0d orph=%0d state=%b required all zero",
                      out_valid, event_count, err_orphan_count, dbg_state);
    end
    model_reset();
    foreach (src_q[i]) model_word(src_q[i]);
    @(posedge clock); #1;
    send(mk_word(1'b1, 8'hAB)); send(mk_word(1'b1, 8'hCD));
    drain(0, 200);
    total++;
    if (got_q.size() != 2) begin bad++; $display("FAIL t6_beats got=%0d required=2", got_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL t6_beat%0d got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++;
    if ({event_count, err_orphan_count, err_nofooter_cnt} !== {32'd1, 32'd4, 32'd0}) begin
      bad++; $display("FAIL t6_counters got=%0d/%0d/%0d required=1/4/0", event_count, err_orphan_count, err_nofooter_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_event();
    test_stall_long();
    test_orphans();
    test_nofooter();
    test_saturate();
    test_random();
    test_reset_mid_event();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
